// File: rtl/bumpy_pkg.sv
// Shared definitions for the Bumpy step layer: tile geometry, step type codes,
// transparent colour and the landing-flash state encoding.
package bumpy_pkg;

    localparam int unsigned TILE_SHIFT = 6;

    localparam logic [2:0] FREE = 3'b000;
    localparam logic [2:0] REGU = 3'b001;

    localparam logic [7:0] TRANSPARENT = 8'hFF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    // Only regular steps carry a visible slab; every other code is see-through.
    function automatic logic step_is_drawn(input logic [2:0] step_code);
        return (step_code == REGU);
    endfunction

endpackage

// File: rtl/step_flash_fsm.sv
// Landing highlight sequencer: counts frames after a landing and produces the
// 2-on / 2-off blink enable for the slab body colour.
module step_flash_fsm
    import bumpy_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic landing,
    output logic flashLit
);

    localparam logic [7:0] LAST_COUNT = FLASH_FRAMES[7:0];

    flash_state_t state_r;
    flash_state_t state_n_s;
    logic [7:0]   frame_cnt_r;
    logic [7:0]   frame_cnt_n_s;
    logic [7:0]   frame_cnt_inc_s;

    assign frame_cnt_inc_s = frame_cnt_r + 8'd1;

    // State and frame counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r     <= IDLE;
            frame_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_n_s;
            frame_cnt_r <= frame_cnt_n_s;
        end
    end

    // Next-state logic; a landing always restarts the flash and beats a frame tick.
    always_comb begin
        state_n_s     = state_r;
        frame_cnt_n_s = frame_cnt_r;
        case (state_r)
            IDLE: begin
                if (landing) begin
                    state_n_s     = FLASH;
                    frame_cnt_n_s = 8'd0;
                end else begin
                    state_n_s     = IDLE;
                    frame_cnt_n_s = frame_cnt_r;
                end
            end
            FLASH: begin
                if (landing) begin
                    state_n_s     = FLASH;
                    frame_cnt_n_s = 8'd0;
                end else if (startOfFrame) begin
                    if (frame_cnt_inc_s == LAST_COUNT) begin
                        state_n_s     = IDLE;
                        frame_cnt_n_s = 8'd0;
                    end else begin
                        state_n_s     = FLASH;
                        frame_cnt_n_s = frame_cnt_inc_s;
                    end
                end else begin
                    state_n_s     = FLASH;
                    frame_cnt_n_s = frame_cnt_r;
                end
            end
            default: begin
                state_n_s     = IDLE;
                frame_cnt_n_s = 8'd0;
            end
        endcase
    end

    assign flashLit = (state_r == FLASH) && (frame_cnt_r[1] == 1'b0);

endmodule

// File: rtl/step_draw.sv
// Step slab renderer: aligns the pixel position with the tile lookup, decides
// slab coverage and colour, and registers the result for the VGA mixer.
module step_draw
    import bumpy_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned SLAB_HEIGHT  = 16,
    parameter logic [7:0]  SLAB_COLOR   = 8'h6C,
    parameter logic [7:0]  EDGE_COLOR   = 8'h24,
    parameter logic [7:0]  FLASH_COLOR  = 8'hFC
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [2:0]  step_type,
    input  logic [10:0] tileTopLeftX,
    input  logic [10:0] tileTopLeftY,
    input  logic        landing,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    // One extra bit so a full-tile-high slab still compares correctly.
    localparam int unsigned             ROW_W     = TILE_SHIFT + 1;
    localparam logic [ROW_W-1:0]        SLAB_ROWS = ROW_W'(SLAB_HEIGHT);
    localparam logic [ROW_W-1:0]        SLAB_LAST = ROW_W'(SLAB_HEIGHT - 32'd1);

    logic [10:0]      px_d_r;
    logic [10:0]      py_d_r;
    logic [10:0]      off_x_s;
    logic [10:0]      off_y_s;
    logic [ROW_W-1:0] row_s;
    logic             edge_row_s;
    logic             flash_lit_s;
    logic             in_slab_s;
    logic [7:0]       rgb_n_s;
    logic             draw_req_r;
    logic [7:0]       rgb_r;
    logic             unused_off_s;

    step_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .landing      (landing),
        .flashLit     (flash_lit_s)
    );

    // Delay the pixel position so it lines up with the step controller's tile lookup.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            px_d_r <= 11'd0;
            py_d_r <= 11'd0;
        end else begin
            px_d_r <= pixelX;
            py_d_r <= pixelY;
        end
    end

    assign off_x_s    = px_d_r - tileTopLeftX;
    assign off_y_s    = py_d_r - tileTopLeftY;
    assign row_s      = {1'b0, off_y_s[TILE_SHIFT-1:0]};
    assign edge_row_s = (row_s == {ROW_W{1'b0}}) || (row_s == SLAB_LAST);

    // The slab spans the full tile width, so the column offset carries no decision.
    assign unused_off_s = ^{off_x_s, off_y_s[10:TILE_SHIFT]};

    // Slab coverage and colour selection for the aligned pixel.
    always_comb begin
        in_slab_s = 1'b0;
        rgb_n_s   = TRANSPARENT;
        if (step_is_drawn(step_type) && (row_s < SLAB_ROWS)) begin
            in_slab_s = 1'b1;
            if (edge_row_s) begin
                rgb_n_s = EDGE_COLOR;
            end else if (flash_lit_s) begin
                rgb_n_s = FLASH_COLOR;
            end else begin
                rgb_n_s = SLAB_COLOR;
            end
        end else begin
            in_slab_s = 1'b0;
            rgb_n_s   = TRANSPARENT;
        end
    end

    // Output registers; request and colour always move together.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            draw_req_r <= 1'b0;
            rgb_r      <= TRANSPARENT;
        end else begin
            draw_req_r <= in_slab_s;
            rgb_r      <= rgb_n_s;
        end
    end

    assign drawingRequest = draw_req_r;
    assign RGBout         = rgb_r;

endmodule

// File: tb/tb_step_draw.sv
// Directed self-checking bench for step_draw: pixel pipeline, slab colouring,
// landing flash sequencing and reset behaviour.
module tb_step_draw;

    localparam logic [2:0] T_FREE  = 3'b000;
    localparam logic [2:0] T_REGU  = 3'b001;
    localparam logic [7:0] C_SLAB  = 8'h6C;
    localparam logic [7:0] C_EDGE  = 8'h24;
    localparam logic [7:0] C_FLASH = 8'hFC;
    localparam logic [7:0] C_NONE  = 8'hFF;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [2:0]  step_type;
    logic [10:0] tileTopLeftX;
    logic [10:0] tileTopLeftY;
    logic        landing;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    int checks = 0;
    int errors = 0;

    step_draw dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .step_type      (step_type),
        .tileTopLeftX   (tileTopLeftX),
        .tileTopLeftY   (tileTopLeftY),
        .landing        (landing),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pixel, then its tile info one cycle later; outputs are valid on return.
    task automatic draw(input logic [10:0] px, input logic [10:0] py, input logic [2:0] st,
                        input logic [10:0] tx, input logic [10:0] ty);
        pixelX = px;
        pixelY = py;
        step();
        step_type    = st;
        tileTopLeftX = tx;
        tileTopLeftY = ty;
        step();
    endtask

    task automatic pulse_landing();
        landing = 1'b1;
        step();
        landing = 1'b0;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        landing      = 1'b0;
        pixelX       = 11'd70;
        pixelY       = 11'd133;
        step_type    = T_REGU;
        tileTopLeftX = 11'd64;
        tileTopLeftY = 11'd128;
        repeat (3) step();
        checks++;
        if (drawingRequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_dr got %b want 0", drawingRequest);
        end
        checks++;
        if (RGBout !== C_NONE) begin
            errors++;
            $display("FAIL reset_rgb got %h want %h", RGBout, C_NONE);
        end
        resetN = 1'b1;
        step();
        step();
        checks++;
        if (drawingRequest !== 1'b1) begin
            errors++;
            $display("FAIL release_dr got %b want 1", drawingRequest);
        end
        checks++;
        if (RGBout !== C_SLAB) begin
            errors++;
            $display("FAIL release_rgb got %h want %h", RGBout, C_SLAB);
        end
    endtask

    task automatic test_pixels();
        logic [10:0] vx  [0:8];
        logic [10:0] vy  [0:8];
        logic [2:0]  vt  [0:8];
        logic [10:0] vtx [0:8];
        logic [10:0] vty [0:8];
        logic        edr [0:8];
        logic [7:0]  ergb[0:8];
        vx   = '{11'd70,  11'd70,  11'd70,  11'd70,  11'd70,  11'd70,   11'd70,  11'd127, 11'd200};
        vy   = '{11'd128, 11'd133, 11'd133, 11'd144, 11'd143, 11'd133,  11'd192, 11'd133, 11'd300};
        vt   = '{T_REGU,  T_REGU,  T_FREE,  T_REGU,  T_REGU,  3'b010,   T_REGU,  T_REGU,  T_REGU};
        vtx  = '{11'd64,  11'd64,  11'd64,  11'd64,  11'd64,  11'd64,   11'd64,  11'd64,  11'd192};
        vty  = '{11'd128, 11'd128, 11'd128, 11'd128, 11'd128, 11'd128,  11'd128, 11'd128, 11'd290};
        edr  = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0,     1'b1,    1'b1,    1'b1};
        ergb = '{C_EDGE,  C_SLAB,  C_NONE,  C_NONE,  C_EDGE,  C_NONE,   C_EDGE,  C_SLAB,  C_SLAB};
        for (int i = 0; i < 9; i++) begin
            draw(vx[i], vy[i], vt[i], vtx[i], vty[i]);
            checks++;
            if (drawingRequest !== edr[i]) begin
                errors++;
                $display("FAIL pixel_dr[%0d] got %b want %b", i, drawingRequest, edr[i]);
            end
            checks++;
            if (RGBout !== ergb[i]) begin
                errors++;
                $display("FAIL pixel_rgb[%0d] got %h want %h", i, RGBout, ergb[i]);
            end
        end
    endtask

    // New pixel every cycle with tile type trailing by one; result expected two cycles later.
    task automatic test_back_to_back();
        logic [10:0] vx  [0:5];
        logic [10:0] vy  [0:5];
        logic [2:0]  vt  [0:5];
        logic        edr [0:5];
        logic [7:0]  ergb[0:5];
        vx   = '{11'd70,  11'd70,  11'd70,  11'd70,  11'd70,  11'd100};
        vy   = '{11'd128, 11'd133, 11'd133, 11'd143, 11'd144, 11'd140};
        vt   = '{T_REGU,  T_REGU,  T_FREE,  T_REGU,  T_REGU,  T_REGU};
        edr  = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
        ergb = '{C_EDGE,  C_SLAB,  C_NONE,  C_EDGE,  C_NONE,  C_SLAB};
        tileTopLeftX = 11'd64;
        tileTopLeftY = 11'd128;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                pixelX = vx[k];
                pixelY = vy[k];
            end
            if (k >= 1 && k <= 6) begin
                step_type = vt[k-1];
            end
            if (k >= 2) begin
                checks++;
                if (drawingRequest !== edr[k-2]) begin
                    errors++;
                    $display("FAIL b2b_dr[%0d] got %b want %b", k - 2, drawingRequest, edr[k-2]);
                end
                checks++;
                if (RGBout !== ergb[k-2]) begin
                    errors++;
                    $display("FAIL b2b_rgb[%0d] got %h want %h", k - 2, RGBout, ergb[k-2]);
                end
            end
            step();
        end
    endtask

    task automatic test_flash();
        logic [7:0] exp_rgb;
        draw(11'd70, 11'd133, T_REGU, 11'd64, 11'd128);
        pulse_landing();
        step();
        checks++;
        if (RGBout !== C_FLASH) begin
            errors++;
            $display("FAIL flash_start got %h want %h", RGBout, C_FLASH);
        end
        draw(11'd70, 11'd128, T_REGU, 11'd64, 11'd128);
        checks++;
        if (RGBout !== C_EDGE) begin
            errors++;
            $display("FAIL flash_edge got %h want %h", RGBout, C_EDGE);
        end
        draw(11'd70, 11'd133, T_REGU, 11'd64, 11'd128);
        for (int f = 1; f <= 9; f++) begin
            pulse_sof();
            step();
            exp_rgb = (f < 8 && (f % 4) < 2) ? C_FLASH : C_SLAB;
            checks++;
            if (RGBout !== exp_rgb) begin
                errors++;
                $display("FAIL flash_frame[%0d] got %h want %h", f, RGBout, exp_rgb);
            end
        end
    endtask

    task automatic test_coincident();
        pulse_landing();
        repeat (5) pulse_sof();
        step();
        checks++;
        if (RGBout !== C_FLASH) begin
            errors++;
            $display("FAIL coinc_cnt5 got %h want %h", RGBout, C_FLASH);
        end
        landing      = 1'b1;
        startOfFrame = 1'b1;
        step();
        landing      = 1'b0;
        startOfFrame = 1'b0;
        step();
        checks++;
        if (RGBout !== C_FLASH) begin
            errors++;
            $display("FAIL coinc_cnt0 got %h want %h", RGBout, C_FLASH);
        end
        pulse_sof();
        step();
        checks++;
        if (RGBout !== C_FLASH) begin
            errors++;
            $display("FAIL coinc_cnt1 got %h want %h", RGBout, C_FLASH);
        end
        pulse_sof();
        step();
        checks++;
        if (RGBout !== C_SLAB) begin
            errors++;
            $display("FAIL coinc_cnt2 got %h want %h", RGBout, C_SLAB);
        end
    endtask

    task automatic test_reset_in_flash();
        pulse_landing();
        repeat (4) pulse_sof();
        step();
        checks++;
        if (drawingRequest !== 1'b1 || RGBout !== C_FLASH) begin
            errors++;
            $display("FAIL rif_pre got %b/%h want 1/%h", drawingRequest, RGBout, C_FLASH);
        end
        resetN       = 1'b0;
        landing      = 1'b1;
        startOfFrame = 1'b1;
        step();
        resetN       = 1'b1;
        landing      = 1'b0;
        startOfFrame = 1'b0;
        checks++;
        if (drawingRequest !== 1'b0) begin
            errors++;
            $display("FAIL rif_dr got %b want 0", drawingRequest);
        end
        checks++;
        if (RGBout !== C_NONE) begin
            errors++;
            $display("FAIL rif_rgb got %h want %h", RGBout, C_NONE);
        end
        step();
        step();
        checks++;
        if (drawingRequest !== 1'b1 || RGBout !== C_SLAB) begin
            errors++;
            $display("FAIL rif_idle got %b/%h want 1/%h", drawingRequest, RGBout, C_SLAB);
        end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_back_to_back();
        test_flash();
        test_coincident();
        test_reset_in_flash();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_draw.md
STEP_DRAW -- requirements
Module: step_draw

Interface
REQ-001 Parameter FLASH_FRAMES, default 8: frames a landing highlight lasts (range 1..255).
REQ-002 Parameter SLAB_HEIGHT, default 16: rows of a REGU tile that are drawn, counted from the tile top.
REQ-003 Parameter SLAB_COLOR, default 8'h6C: slab body colour (RGB332).
REQ-004 Parameter EDGE_COLOR, default 8'h24: colour of slab row 0 and row SLAB_HEIGHT-1.
REQ-005 Parameter FLASH_COLOR, default 8'hFC: slab body colour during a lit flash phase.
REQ-006 clk  in  1  system clock, all logic rising-edge.
REQ-007 resetN  in  1  synchronous active-low reset.
REQ-008 startOfFrame  in  1  one-cycle pulse per VGA frame.
REQ-009 pixelX  in  11  current VGA pixel column.
REQ-010 pixelY  in  11  current VGA pixel row.
REQ-011 step_type  in  3  tile type from the step controller, registered one cycle after pixelX/pixelY.
REQ-012 tileTopLeftX  in  11  tile origin X, same alignment as step_type.
REQ-013 tileTopLeftY  in  11  tile origin Y, same alignment as step_type.
REQ-014 landing  in  1  one-cycle pulse when Bumpy lands on any step.
REQ-015 drawingRequest  out  1  high when the current pixel belongs to a step.
REQ-016 RGBout  out  8  step pixel colour (RGB332); 8'hFF when drawingRequest is low.

Function
REQ-017 pixelX and pixelY SHALL be delayed one cycle (pX_d, pY_d) so they align with step_type and tileTopLeft.
REQ-018 offX = pX_d - tileTopLeftX and offY = pY_d - tileTopLeftY SHALL be computed in 11 bits; only bits [5:0] are used.
REQ-019 inSlab SHALL be true when step_type == REGU and offY < SLAB_HEIGHT; FREE and all other codes are never drawn.
REQ-020 drawingRequest SHALL be registered and equal inSlab, so the response to a pixel presented at cycle n appears at cycle n+2.
REQ-021 RGBout SHALL be registered with drawingRequest: EDGE_COLOR on edge rows; on other slab rows, FLASH_COLOR when flashLit, else SLAB_COLOR; 8'hFF when not inSlab.
REQ-022 The FSM SHALL have states IDLE and FLASH.
REQ-023 IDLE -> FLASH on landing; frameCnt is cleared to 0.
REQ-024 In FLASH, each startOfFrame SHALL increment the 8-bit frameCnt; when an increment would reach FLASH_FRAMES, the state returns to IDLE and frameCnt clears.
REQ-025 landing while in FLASH SHALL restart the flash: state stays FLASH, frameCnt = 0.
REQ-026 landing and startOfFrame in the same cycle: landing wins, frameCnt = 0, no increment.
REQ-027 flashLit = (state == FLASH) and (frameCnt[1] == 0), giving a 2-frames-on / 2-frames-off blink.
REQ-028 The FSM change SHALL take effect on RGBout for pixels whose colour register is loaded after the transition; mid-frame changes are allowed.

Reset
REQ-029 While resetN is low at a clock edge: drawingRequest = 0, RGBout = 8'hFF, state = IDLE, frameCnt = 0, pX_d = pY_d = 0.
REQ-030 Reset SHALL override landing and startOfFrame in the same cycle; reset during FLASH aborts the flash.
REQ-031 The first valid output after reset release SHALL be at the second clock edge.

Structure
REQ-032 A shared package bumpy_pkg SHALL hold the step type constants FREE = 3'b000 and REGU = 3'b001, TRANSPARENT = 8'hFF, and the FSM state enum.
REQ-033 The tile-size shift (6) SHALL be a package constant shared with the step controller.
REQ-034 One sub-module, step_flash_fsm, SHALL own the state, frameCnt and flashLit; the pixel pipeline stays in step_draw.

Verification
REQ-035 Pixel (70,128), tile (64,128), REGU, state IDLE -> two cycles later drawingRequest = 1, RGBout = EDGE_COLOR.
REQ-036 Pixel (70,133), tile (64,128), REGU, state IDLE -> drawingRequest = 1, RGBout = 8'h6C; the same pixel with FREE -> drawingRequest = 0, RGBout = 8'hFF.
REQ-037 Pixel offY = 16, REGU -> drawingRequest = 0, RGBout = 8'hFF.
REQ-038 landing pulse, then 8 startOfFrame pulses:
- frames 0-1: body = FLASH_COLOR;
- frames 2-3: body = SLAB_COLOR;
- frames 4-5: body = FLASH_COLOR;
- frames 6-7: body = SLAB_COLOR;
- after the 8th pulse: IDLE.
REQ-039 landing coincident with startOfFrame at frameCnt = 5 -> frameCnt = 0, state = FLASH.
REQ-040 resetN low for 1 cycle during FLASH while drawingRequest = 1 -> next edge drawingRequest = 0, RGBout = 8'hFF, state = IDLE.
